// File: rtl/seven_seg_pkg.sv
// Shared constants for the 7-segment capture path: the active-low hex glyph table,
// the all-off pattern and the width of a digit index.
package seven_seg_pkg;

    localparam int DIGIT_IDX_W = 3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g..a} glyphs for nibbles 0..F; index equals the decoded value.
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational lookup of one normalised active-low segment pattern back to a hex nibble,
// flagging the all-off pattern separately from table hits.
module seg_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic       hit,
    output logic       is_blank,
    output logic [3:0] nibble
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
        hit      = 1'b0;
        nibble   = 4'h0;
        is_blank = (seg_n == SEG_BLANK);
        for (int k = 0; k < 16; k++) begin
            if (seg_n == SEG_HEX[k]) begin
                hit    = 1'b1;
                nibble = 4'(k);
            end
        end
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Receive side of a multiplexed 7-segment bus: waits for a strobed pattern to stay stable,
// then commits its decoded nibble and status into that digit's readback slot.
module seven_segment_capture
    import seven_seg_pkg::*;
#(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4,
    parameter bit ACTIVE_LOW    = 1'b1
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [6:0]             seg_in,
    input  logic [DIGITS-1:0]      dig_en,
    output logic [4*DIGITS-1:0]    value,
    output logic [DIGITS-1:0]      blank,
    output logic [DIGITS-1:0]      invalid,
    output logic                   update,
    output logic [DIGIT_IDX_W-1:0] upd_idx,
    output logic                   err_multi
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SW    = 1 + DIGITS + 7;

    logic [6:0]             seg_n;
    logic                   ok;
    logic                   multi;
    logic                   same;
    logic                   commit;
    logic [DIGIT_IDX_W-1:0] idx;
    logic [SW-1:0]          s_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DIGITS-1:0][3:0] value_q;

    logic                   dec_hit;
    logic                   dec_blank;
    logic [3:0]             dec_nibble;

    seg_pattern_decode u_decode (
        .seg_n    (seg_n),
        .hit      (dec_hit),
        .is_blank (dec_blank),
        .nibble   (dec_nibble)
    );

    always_comb begin
        seg_n  = ACTIVE_LOW ? seg_in : ~seg_in;
        ok     = $onehot(dig_en);
        multi  = (dig_en != '0) && !ok;
        same   = ({ok, dig_en, seg_n} == s_q);
        commit = ok && same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
        idx    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (dig_en[i]) idx = DIGIT_IDX_W'(i);
        end
    end

    // Saturation at STABLE_CYCLES is what limits a held pattern to a single commit.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them see pre-edge values.
        if (rst) begin
            // NOTE: the per-digit readback registers are reset too, so software sees defined values.
            s_q       <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            blank     <= '1;
            invalid   <= '0;
            update    <= 1'b0;
            upd_idx   <= '0;
            err_multi <= 1'b0;
        end else begin
            s_q       <= {ok, dig_en, seg_n};
            err_multi <= multi;
            update    <= commit;

            if (!ok)
                cnt_q <= '0;
            else if (same)
                cnt_q <= (cnt_q == CNT_W'(STABLE_CYCLES)) ? cnt_q : cnt_q + CNT_W'(1);
            else
                cnt_q <= CNT_W'(1);

            if (commit) upd_idx <= idx;

            for (int i = 0; i < DIGITS; i++) begin
                if (commit && dig_en[i]) begin
                    value_q[i] <= dec_hit ? dec_nibble : 4'h0;
                    blank[i]   <= dec_blank;
                    invalid[i] <= !dec_hit && !dec_blank;
                end
            end
        end
    end

    assign value = value_q;

endmodule

// File: tb/tb_seven_segment_capture.sv
// Self-checking bench: an active-low DUT and an active-high DUT fed the complementary lines,
// both checked every cycle against a history-window reference model.
module tb_seven_segment_capture;

    localparam int DIGITS = 8;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_in;
    logic [6:0]  seg_in_inv;
    logic [7:0]  dig_en;

    logic [31:0] value_a, value_b;
    logic [7:0]  blank_a, blank_b, invalid_a, invalid_b;
    logic        update_a, update_b, err_a, err_b;
    logic [2:0]  idx_a, idx_b;

    assign seg_in_inv = ~seg_in;

    always #5 clk = ~clk;

    seven_segment_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
        .value(value_a), .blank(blank_a), .invalid(invalid_a),
        .update(update_a), .upd_idx(idx_a), .err_multi(err_a)
    );

    seven_segment_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .ACTIVE_LOW(1'b0)) dut_b (
        .clk(clk), .rst(rst), .seg_in(seg_in_inv), .dig_en(dig_en),
        .value(value_b), .blank(blank_b), .invalid(invalid_b),
        .update(update_b), .upd_idx(idx_b), .err_multi(err_b)
    );

    // Reference model: commit when the last STABLE samples are one identical valid strobe
    // and the sample just before them (if any since reset) was not part of that run.
    typedef struct {
        bit         ok;
        logic [7:0] dig;
        logic [6:0] seg;
    } samp_t;

    typedef struct {
        logic [7:0]  dig;
        logic [6:0]  seg;
        int          hold;
        logic [31:0] exp_value;
        logic [7:0]  exp_blank;
        logic [7:0]  exp_invalid;
    } vec_t;

    logic [6:0] hex_tab [16];
    samp_t      hist [$];
    logic [3:0] m_val [8];
    logic [7:0] m_blank, m_inv;
    bit         m_upd, m_err;
    int         m_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int upd_seen = 0;
    int err_seen = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_word();
        logic [31:0] w;
        for (int i = 0; i < 8; i++) w[4*i +: 4] = m_val[i];
        return w;
    endfunction

    task automatic model_edge(bit r, logic [7:0] d, logic [6:0] s);
        samp_t x;
        bit    commit;
        bit    found;
        int    n;
        if (r) begin
            hist.delete();
            for (int i = 0; i < 8; i++) m_val[i] = 4'h0;
            m_blank = 8'hFF;
            m_inv   = 8'h00;
            m_upd   = 1'b0;
            m_idx   = 0;
            m_err   = 1'b0;
        end else begin
            x.ok  = ($countones(d) == 1);
            x.dig = d;
            x.seg = s;
            hist.push_back(x);
            if (hist.size() > STABLE + 1) void'(hist.pop_front());
            n = hist.size();
            commit = (n >= STABLE);
            if (commit) begin
                for (int k = n - STABLE; k < n; k++)
                    if (!hist[k].ok || hist[k].dig != d || hist[k].seg != s) commit = 1'b0;
            end
            if (commit && n == STABLE + 1 && hist[0].ok && hist[0].dig == d && hist[0].seg == s)
                commit = 1'b0;
            m_err = (d != 8'h00) && !x.ok;
            m_upd = commit;
            if (commit) begin
                for (int i = 0; i < 8; i++) if (d[i]) m_idx = i;
                found = 1'b0;
                m_val[m_idx] = 4'h0;
                for (int c = 0; c < 16; c++) begin
                    if (hex_tab[c] == s) begin
                        found = 1'b1;
                        m_val[m_idx] = 4'(c);
                    end
                end
                m_blank[m_idx] = (s == 7'h7F);
                m_inv[m_idx]   = !found && (s != 7'h7F);
            end
        end
    endtask

    task automatic compare_all();
        check("value_a",   value_a,          m_word());
        check("value_b",   value_b,          m_word());
        check("blank_a",   32'(blank_a),     32'(m_blank));
        check("blank_b",   32'(blank_b),     32'(m_blank));
        check("invalid_a", 32'(invalid_a),   32'(m_inv));
        check("invalid_b", 32'(invalid_b),   32'(m_inv));
        check("update_a",  32'(update_a),    32'(m_upd));
        check("update_b",  32'(update_b),    32'(m_upd));
        check("err_a",     32'(err_a),       32'(m_err));
        check("err_b",     32'(err_b),       32'(m_err));
        if (m_upd) begin
            check("upd_idx_a", 32'(idx_a), 32'(m_idx));
            check("upd_idx_b", 32'(idx_b), 32'(m_idx));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare 1 ns later.
    task automatic step(bit r, logic [7:0] d, logic [6:0] s);
        rst    = r;
        dig_en = d;
        seg_in = s;
        @(posedge clk);
        model_edge(r, d, s);
        #1;
        if (update_a) upd_seen++;
        if (err_a) err_seen++;
        compare_all();
    endtask

    task automatic check_reset_state(string tag);
        check({tag, "_value"},   value_a,        32'h0);
        check({tag, "_blank"},   32'(blank_a),   32'hFF);
        check({tag, "_invalid"}, 32'(invalid_a), 32'h0);
        check({tag, "_update"},  32'(update_a),  32'h0);
        check({tag, "_upd_idx"}, 32'(idx_a),     32'h0);
        check({tag, "_err"},     32'(err_a),     32'h0);
    endtask

    vec_t vecs [9];

    initial begin
        hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vecs[0] = '{8'h04, 7'h30, 4, 32'h0000_0300, 8'hFB, 8'h00};
        vecs[1] = '{8'h01, 7'h0E, 3, 32'h0000_0300, 8'hFB, 8'h00};
        vecs[2] = '{8'h01, 7'h06, 4, 32'h0000_030E, 8'hFA, 8'h00};
        vecs[3] = '{8'h80, 7'h7F, 4, 32'h0000_030E, 8'hFA, 8'h00};
        vecs[4] = '{8'h80, 7'h55, 4, 32'h0000_030E, 8'h7A, 8'h80};
        vecs[5] = '{8'h80, 7'h40, 4, 32'h0000_030E, 8'h7A, 8'h00};
        vecs[6] = '{8'h40, 7'h12, 4, 32'h0500_030E, 8'h3A, 8'h00};
        vecs[7] = '{8'h02, 7'h00, 2, 32'h0500_030E, 8'h3A, 8'h00};
        vecs[8] = '{8'h02, 7'h78, 5, 32'h0500_037E, 8'h38, 8'h00};

        step(1'b1, 8'h00, 7'h7F);
        step(1'b1, 8'h00, 7'h7F);
        check_reset_state("reset");

        // Stable-run table: every cycle model-checked, final state checked against constants.
        for (int v = 0; v < 9; v++) begin
            for (int c = 0; c < vecs[v].hold; c++) step(1'b0, vecs[v].dig, vecs[v].seg);
            check($sformatf("vec%0d_value", v),   value_a,        vecs[v].exp_value);
            check($sformatf("vec%0d_blank", v),   32'(blank_a),   32'(vecs[v].exp_blank));
            check($sformatf("vec%0d_invalid", v), 32'(invalid_a), 32'(vecs[v].exp_invalid));
        end

        // A pattern held for 20 cycles commits exactly once.
        upd_seen = 0;
        for (int c = 0; c < 20; c++) step(1'b0, 8'h10, 7'h21);
        check("hold20_updates", 32'(upd_seen), 32'd1);
        check("hold20_digit4", 32'(value_a[19:16]), 32'hD);

        // Multi-strobe flags every cycle, idle flags nothing.
        upd_seen = 0;
        err_seen = 0;
        for (int c = 0; c < 6; c++) step(1'b0, 8'h03, 7'h40);
        check("multi_err_count", 32'(err_seen), 32'd6);
        check("multi_updates", 32'(upd_seen), 32'd0);
        upd_seen = 0;
        err_seen = 0;
        for (int c = 0; c < 10; c++) step(1'b0, 8'h00, 7'h40);
        check("idle_err_count", 32'(err_seen), 32'd0);
        check("idle_updates", 32'(upd_seen), 32'd0);

        // Reset on the third edge of a run discards it; the restarted run has not yet committed.
        upd_seen = 0;
        step(1'b0, 8'h08, 7'h19);
        step(1'b0, 8'h08, 7'h19);
        step(1'b1, 8'h08, 7'h19);
        check_reset_state("midrst");
        step(1'b0, 8'h08, 7'h19);
        step(1'b0, 8'h08, 7'h19);
        check("midrst_updates", 32'(upd_seen), 32'd0);

        // Sweep all 16 glyphs over all 8 digits on both input polarities.
        for (int p = 0; p < 2; p++) begin
            for (int d = 0; d < 8; d++)
                for (int c = 0; c < STABLE; c++)
                    step(1'b0, 8'(1 << d), hex_tab[(p == 0) ? 8 + d : d]);
            check($sformatf("sweep%0d_value_a", p), value_a, (p == 0) ? 32'hFEDC_BA98 : 32'h7654_3210);
            check($sformatf("sweep%0d_value_b", p), value_b, (p == 0) ? 32'hFEDC_BA98 : 32'h7654_3210);
            check($sformatf("sweep%0d_blank_b", p), 32'(blank_b), 32'h0);
        end

        // Random bursts: glitches, idle, multi-strobe, blank and non-hex patterns.
        for (int t = 0; t < 250; t++) begin
            logic [7:0] d;
            logic [6:0] s;
            int         kind;
            int         sk;
            int         hold;
            kind = $urandom_range(0, 9);
            if (kind == 0)
                d = 8'h00;
            else if (kind == 1) begin
                d = 8'($urandom);
                if ($countones(d) < 2) d = 8'h81;
            end else
                d = 8'(1 << $urandom_range(0, 7));
            sk = $urandom_range(0, 5);
            if (sk == 0)
                s = 7'h7F;
            else if (sk == 1)
                s = 7'($urandom);
            else
                s = hex_tab[$urandom_range(0, 15)];
            hold = $urandom_range(1, 6);
            for (int c = 0; c < hold; c++) step(1'b0, d, s);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
